sm83_bus_responder: RTL and testbench

- Memory-side responder for the SM83 core's bus; the target end of the accesses the control sequencer initiates (fetch, operand read, r8/Z store).
- Decodes each CPU request and serves WRAM, HRAM and the IE register internally.
- Forwards all other addresses to an external port (cartridge/MBC, VRAM, IO) through a req/ack handshake with a timeout.
- Sits between the core's address/data mux and the SoC peripherals.

---
 rtl/sm83_pkg.sv | 50 +++++
 rtl/sm83_spram.sv | 32 +++
 rtl/sm83_bus_responder.sv | 172 +++++++++++++++++
 tb/tb_sm83_bus_responder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm83_pkg.sv
// Shared types, address map and decode for the SM83 bus responder.
// Optional build macro: SM83_ECHO_RAM_EN (echo RAM at 0xE000-0xFDFF aliases WRAM).
package sm83_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    EXT_WAIT
  } bus_state_t;

  typedef enum logic [1:0] {
    INT_WRAM,
    INT_HRAM,
    INT_IE,
    EXT
  } bus_region_t;

  localparam logic [15:0] WRAM_BASE = 16'hC000;
  localparam logic [15:0] WRAM_END  = 16'hDFFF;
  localparam logic [15:0] ECHO_BASE = 16'hE000;
  localparam logic [15:0] ECHO_END  = 16'hFDFF;
  localparam logic [15:0] HRAM_BASE = 16'hFF80;
  localparam logic [15:0] IE_ADDR   = 16'hFFFF;

  // Read data returned when an external access is abandoned.
  localparam logic [7:0]  TIMEOUT_RDATA = 8'hFF;

  // Map a CPU byte address onto the region that serves it. IE is tested
  // before HRAM because 0xFFFF sits just above the HRAM window.
  function automatic bus_region_t decode_region(input logic [15:0] addr);
    bus_region_t region;
    if (addr >= WRAM_BASE && addr <= WRAM_END) begin
      region = INT_WRAM;
    end
`ifdef SM83_ECHO_RAM_EN
    else if (addr >= ECHO_BASE && addr <= ECHO_END) begin
      region = INT_WRAM;
    end
`endif
    else if (addr == IE_ADDR) begin
      region = INT_IE;
    end else if (addr >= HRAM_BASE) begin
      region = INT_HRAM;
    end else begin
      region = EXT;
    end
    return region;
  endfunction

endpackage

// File: rtl/sm83_spram.sv
// Synchronous single-port RAM: write and read share one address; the read
// data appears the cycle after the enabled access (read-before-write).
module sm83_spram #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rdata;

  // Storage array and registered read port.
  // NOTE: the array has no reset -- clearing thousands of words is not
  // possible in a RAM macro, so contents are undefined until written.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sm83_bus_responder.sv
// Memory-side responder for the SM83 core bus. Serves WRAM, HRAM and IE
// internally and forwards every other address to an external req/ack port
// guarded by a timeout.
// Optional build macro: SM83_ECHO_RAM_EN (decoded in sm83_pkg).
module sm83_bus_responder
  import sm83_pkg::*;
#(
  parameter int WRAM_AW = 13,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [15:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_wdata,
  output logic        o_cpu_ready,
  output logic        o_cpu_ack,
  output logic [7:0]  o_cpu_rdata,
  output logic        o_ext_req,
  output logic        o_ext_we,
  output logic [15:0] o_ext_addr,
  output logic [7:0]  o_ext_wdata,
  input  logic        i_ext_ack,
  input  logic [7:0]  i_ext_rdata,
  output logic [7:0]  o_ie_q,
  output logic        o_bus_err,
  input  logic        i_err_clr
);

  // Counter value at which the current EXT_WAIT cycle is the last one allowed.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  bus_state_t  r_state;
  bus_region_t w_region;
  logic        w_accept;
  logic        w_ram_en;
  logic [7:0]  w_ram_q;

  logic        r_ack;
  logic        r_rd_ram;    // response data comes straight from the WRAM port
  logic [7:0]  r_rdata;
  logic        r_ext_req;
  logic        r_ext_we;
  logic [15:0] r_ext_addr;
  logic [7:0]  r_ext_wdata;
  logic [7:0]  r_ie;
  logic        r_bus_err;
  logic [7:0]  r_cnt;
  logic [7:0]  r_hram [0:127];

  assign o_cpu_ready = (r_state == IDLE);
  assign w_accept    = i_cpu_req && o_cpu_ready;
  assign w_region    = decode_region(i_cpu_addr);
  assign w_ram_en    = w_accept && (w_region == INT_WRAM);

  sm83_spram #(
    .AW (WRAM_AW),
    .DW (8)
  ) u_wram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (i_cpu_we),
    .i_addr  (i_cpu_addr[WRAM_AW-1:0]),
    .i_wdata (i_cpu_wdata),
    .o_rdata (w_ram_q)
  );

  // HRAM flop array; like WRAM its contents survive reset.
  always_ff @(posedge clk) begin
    if (w_accept && i_cpu_we && (w_region == INT_HRAM)) begin
      r_hram[i_cpu_addr[6:0]] <= i_cpu_wdata;
    end
  end

  // Access sequencer: accepts a request in IDLE, answers internal regions
  // one cycle later and tracks the external handshake and its timeout.
  // NOTE: every register here uses <= so all branches see the values from
  // before the edge; the later bus_err set deliberately overrides err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ack       <= 1'b0;
      r_rd_ram    <= 1'b0;
      r_rdata     <= 8'h00;
      r_ext_req   <= 1'b0;
      r_ext_we    <= 1'b0;
      r_ext_addr  <= 16'h0000;
      r_ext_wdata <= 8'h00;
      r_ie        <= 8'h00;
      r_bus_err   <= 1'b0;
      r_cnt       <= 8'h00;
    end else begin
      if (i_err_clr) begin
        r_bus_err <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          r_ack <= 1'b0;
          if (w_accept) begin
            case (w_region)
              INT_WRAM: begin
                r_rd_ram <= !i_cpu_we;
                r_rdata  <= 8'h00;
                r_ack    <= 1'b1;
                r_state  <= RESP;
              end
              INT_HRAM: begin
                r_rdata <= i_cpu_we ? 8'h00 : r_hram[i_cpu_addr[6:0]];
                r_ack   <= 1'b1;
                r_state <= RESP;
              end
              INT_IE: begin
                if (i_cpu_we) begin
                  r_ie <= i_cpu_wdata;
                end
                r_rdata <= i_cpu_we ? 8'h00 : r_ie;
                r_ack   <= 1'b1;
                r_state <= RESP;
              end
              default: begin
                r_ext_req   <= 1'b1;
                r_ext_we    <= i_cpu_we;
                r_ext_addr  <= i_cpu_addr;
                r_ext_wdata <= i_cpu_wdata;
                r_cnt       <= 8'h00;
                r_state     <= EXT_WAIT;
              end
            endcase
          end
        end
        RESP: begin
          r_ack    <= 1'b0;
          r_rd_ram <= 1'b0;
          r_rdata  <= 8'h00;
          r_state  <= IDLE;
        end
        EXT_WAIT: begin
          if (i_ext_ack) begin
            // An ack in the final allowed cycle still completes normally.
            r_ext_req <= 1'b0;
            r_rdata   <= i_ext_rdata;
            r_ack     <= 1'b1;
            r_state   <= RESP;
          end else if (r_cnt == TO_LAST) begin
            r_ext_req <= 1'b0;
            r_bus_err <= 1'b1;
            r_rdata   <= TIMEOUT_RDATA;
            r_ack     <= 1'b1;
            r_cnt     <= r_cnt + 8'd1;
            r_state   <= RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_cpu_ack   = r_ack;
  assign o_cpu_rdata = r_rd_ram ? w_ram_q : r_rdata;
  assign o_ext_req   = r_ext_req;
  assign o_ext_we    = r_ext_we;
  assign o_ext_addr  = r_ext_addr;
  assign o_ext_wdata = r_ext_wdata;
  assign o_ie_q      = r_ie;
  assign o_bus_err   = r_bus_err;

endmodule

// File: tb/tb_sm83_bus_responder.sv
// Self-checking bench for sm83_bus_responder: directed scenarios plus a
// randomized access stream compared against a memory-map model.
module tb_sm83_bus_responder;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ready, cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        ext_req, ext_we;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic        ext_ack;
  logic [7:0]  ext_rdata;
  logic [7:0]  ie_q;
  logic        bus_err;
  logic        err_clr;

  int errors = 0;
  int checks = 0;

  // Reference model of the memory map.
  logic [7:0] m_wram [8192];
  bit         m_wv   [8192];
  logic [7:0] m_hram [128];
  bit         m_hv   [128];
  logic [7:0] m_ie;
  bit         m_err;

  sm83_bus_responder #(.WRAM_AW(13), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cpu_req   (cpu_req),
    .i_cpu_we    (cpu_we),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_wdata (cpu_wdata),
    .o_cpu_ready (cpu_ready),
    .o_cpu_ack   (cpu_ack),
    .o_cpu_rdata (cpu_rdata),
    .o_ext_req   (ext_req),
    .o_ext_we    (ext_we),
    .o_ext_addr  (ext_addr),
    .o_ext_wdata (ext_wdata),
    .i_ext_ack   (ext_ack),
    .i_ext_rdata (ext_rdata),
    .o_ie_q      (ie_q),
    .o_bus_err   (bus_err),
    .i_err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0 = WRAM, 1 = HRAM, 2 = IE, 3 = external
  function automatic int m_region(input logic [15:0] a);
    if (a >= 16'hC000 && a <= 16'hDFFF) return 0;
`ifdef SM83_ECHO_RAM_EN
    if (a >= 16'hE000 && a <= 16'hFDFF) return 0;
`endif
    if (a == 16'hFFFF) return 2;
    if (a >= 16'hFF80) return 1;
    return 3;
  endfunction

  // One complete CPU access. d: ext_ack is given d cycles after ext_req
  // rises (d >= TIMEOUT means never). clr_at_set pulses err_clr in the
  // cycle a timeout fires. noise wiggles ignored inputs while busy.
  task automatic access(input bit we, input logic [15:0] addr, input logic [7:0] wd,
                        input int d, input bit clr_at_set, input bit noise);
    int         rg;
    int         idx;
    logic [7:0] exp;
    bit         exp_valid;
    bit         acked;
    logic [7:0] erd;
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b1 || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL idle_state addr=%h ready=%b ack=%b required ready=1 ack=0", addr, cpu_ready, cpu_ack);
    end
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    ext_ack = noise ? 1'($urandom) : 1'b0;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
    rg = m_region(addr);
    if (rg != 3) begin
      exp = 8'h00; exp_valid = 1'b1;
      if (rg == 0) begin
        idx = (addr >= 16'hE000) ? int'(addr - 16'hE000) : int'(addr - 16'hC000);
        if (we) begin m_wram[idx] = wd; m_wv[idx] = 1'b1; end
        else begin exp = m_wram[idx]; exp_valid = m_wv[idx]; end
      end else if (rg == 1) begin
        idx = int'(addr - 16'hFF80);
        if (we) begin m_hram[idx] = wd; m_hv[idx] = 1'b1; end
        else begin exp = m_hram[idx]; exp_valid = m_hv[idx]; end
      end else begin
        if (we) m_ie = wd;
        else exp = m_ie;
      end
      @(negedge clk);
      ext_ack = noise ? 1'($urandom) : 1'b0;
      checks++;
      if (cpu_ack !== 1'b1 || cpu_ready !== 1'b0 || ext_req !== 1'b0) begin
        errors++;
        $display("FAIL int_resp addr=%h ack=%b ready=%b ext_req=%b required 1/0/0", addr, cpu_ack, cpu_ready, ext_req);
      end
      if (exp_valid) begin
        checks++;
        if (cpu_rdata !== exp) begin
          errors++;
          $display("FAIL int_rdata addr=%h we=%b got=%h required=%h", addr, we, cpu_rdata, exp);
        end
      end
      checks++;
      if (ie_q !== m_ie) begin
        errors++;
        $display("FAIL ie_q addr=%h got=%h required=%h", addr, ie_q, m_ie);
      end
    end else begin
      erd = 8'($urandom);
      acked = 1'b0;
      for (int k = 1; k <= TIMEOUT && !acked; k++) begin
        @(negedge clk);
        ext_ack = 1'b0;
        checks++;
        if (ext_req !== 1'b1 || ext_addr !== addr || ext_we !== we ||
            (we && ext_wdata !== wd) || cpu_ack !== 1'b0 || cpu_ready !== 1'b0) begin
          errors++;
          $display("FAIL ext_wait k=%0d req=%b addr=%h we=%b wd=%h ack=%b ready=%b required 1/%h/%b/%h/0/0",
                   k, ext_req, ext_addr, ext_we, ext_wdata, cpu_ack, cpu_ready, addr, we, wd);
        end
        if (noise) begin
          cpu_req = 1'($urandom); cpu_we = 1'($urandom);
          cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
        end
        if (k == d + 1) begin
          ext_ack = 1'b1; ext_rdata = erd; acked = 1'b1;
        end
        if (k == TIMEOUT && clr_at_set) err_clr = 1'b1;
      end
      @(negedge clk);
      cpu_req = 1'b0;
      err_clr = 1'b0;
      ext_ack = noise ? 1'($urandom) : 1'b0;
      ext_rdata = 8'($urandom);
      if (!acked) m_err = 1'b1;
      checks++;
      if (ext_req !== 1'b0 || cpu_ack !== 1'b1 || cpu_ready !== 1'b0) begin
        errors++;
        $display("FAIL ext_resp addr=%h ext_req=%b ack=%b ready=%b required 0/1/0", addr, ext_req, cpu_ack, cpu_ready);
      end
      if (!we || !acked) begin
        checks++;
        if (cpu_rdata !== (acked ? erd : 8'hFF)) begin
          errors++;
          $display("FAIL ext_rdata addr=%h got=%h required=%h", addr, cpu_rdata, acked ? erd : 8'hFF);
        end
      end
      checks++;
      if (bus_err !== m_err) begin
        errors++;
        $display("FAIL bus_err addr=%h got=%b required=%b", addr, bus_err, m_err);
      end
    end
  endtask

  task automatic clear_err();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_err = 1'b0;
    checks++;
    if (bus_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clr got=%b required=0", bus_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (cpu_ack !== 1'b0 || cpu_rdata !== 8'h00 || ext_req !== 1'b0 || ext_we !== 1'b0 ||
        ext_addr !== 16'h0000 || ext_wdata !== 8'h00 || ie_q !== 8'h00 || bus_err !== 1'b0 ||
        cpu_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_values ack=%b rdata=%h req=%b we=%b addr=%h wd=%h ie=%h err=%b ready=%b required all zero, ready=1",
               cpu_ack, cpu_rdata, ext_req, ext_we, ext_addr, ext_wdata, ie_q, bus_err, cpu_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_wram();
    access(1'b1, 16'hC123, 8'h5A, 0, 1'b0, 1'b0);
    access(1'b0, 16'hC123, 8'h00, 0, 1'b0, 1'b0);
    access(1'b1, 16'hDFFF, 8'h3C, 0, 1'b0, 1'b0);
    access(1'b0, 16'hDFFF, 8'h00, 0, 1'b0, 1'b0);
  endtask

  task automatic test_ie_hram();
    access(1'b1, 16'hFFFF, 8'h1F, 0, 1'b0, 1'b0);
    access(1'b0, 16'hFFFF, 8'h00, 0, 1'b0, 1'b0);
    access(1'b1, 16'hFF80, 8'hA1, 0, 1'b0, 1'b0);
    access(1'b1, 16'hFFFE, 8'h5E, 0, 1'b0, 1'b0);
    access(1'b0, 16'hFF80, 8'h00, 0, 1'b0, 1'b0);
    access(1'b0, 16'hFFFE, 8'h00, 0, 1'b0, 1'b0);
  endtask

  task automatic test_ext();
    access(1'b0, 16'h0150, 8'h00, 3, 1'b0, 1'b0);
    access(1'b0, 16'h4000, 8'h00, 0, 1'b0, 1'b0);
    access(1'b1, 16'h2000, 8'h05, 1, 1'b0, 1'b0);
    access(1'b0, 16'hFF7F, 8'h00, 2, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    access(1'b0, 16'h8000, 8'h00, TIMEOUT + 4, 1'b0, 1'b0);
    clear_err();
    access(1'b0, 16'h8001, 8'h00, TIMEOUT, 1'b1, 1'b0);
    clear_err();
    access(1'b0, 16'h8002, 8'h00, TIMEOUT - 1, 1'b0, 1'b0);
    access(1'b0, 16'h8003, 8'h00, TIMEOUT, 1'b0, 1'b0);
    clear_err();
  endtask

  task automatic test_echo();
    access(1'b1, 16'hC123, 8'h77, 0, 1'b0, 1'b0);
    access(1'b0, 16'hE123, 8'h00, 1, 1'b0, 1'b0);
    access(1'b0, 16'hFE00, 8'h00, 1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] a;
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 4))
        0: a = 16'hC000 + 16'($urandom_range(0, 16'h1FFF));
        1: a = 16'hFF80 + 16'($urandom_range(0, 126));
        2: a = 16'hFFFF;
        3: a = 16'($urandom);
        default: a = 16'hE000 + 16'($urandom_range(0, 16'h1DFF));
      endcase
      access(1'($urandom), a, 8'($urandom), $urandom_range(0, 20), 1'b0, 1'b1);
      if (m_err) clear_err();
    end
  endtask

  task automatic test_reset_mid();
    access(1'b1, 16'hC000, 8'hA5, 0, 1'b0, 1'b0);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4000;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ext_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre_reset ext_req=%b required=1", ext_req);
    end
    #2 rst_n = 1'b0;
    #1;
    m_ie = 8'h00;
    m_err = 1'b0;
    checks++;
    if (ext_req !== 1'b0 || cpu_ack !== 1'b0 || cpu_ready !== 1'b1 || ie_q !== 8'h00 ||
        bus_err !== 1'b0 || ext_addr !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset req=%b ack=%b ready=%b ie=%h err=%b addr=%h required 0/0/1/00/0/0000",
               ext_req, cpu_ack, cpu_ready, ie_q, bus_err, ext_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 16'hC000, 8'h00, 0, 1'b0, 1'b0);
  endtask

  initial begin
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    ext_ack = 1'b0; ext_rdata = 8'h00; err_clr = 1'b0;
    m_ie = 8'h00; m_err = 1'b0;
    test_reset();
    test_wram();
    test_ie_hram();
    test_ext();
    test_timeout();
    test_echo();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
